// File: rtl/jam_cost_rom.sv
// Cost table for the job-assignment search: an 8x8 table of 7-bit costs loaded once
// over a valid/ready stream, then served with a one-cycle registered lookup.
module jam_cost_rom (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LoadStart,
  input  logic        LoadValid,
  input  logic [6:0]  LoadData,
  output logic        LoadReady,
  output logic        TableReady,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  output logic [12:0] Checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [12:0] acc_q, acc_d;
  logic [12:0] checksum_q, checksum_d;
  logic [6:0]  cost_q, cost_d;
  logic        load_ready_q, load_ready_d;
  logic        table_ready_q, table_ready_d;
  logic        wr_en_s;
  logic [6:0]  mem_q [64];

  // Next-state, load bookkeeping and lookup; LoadStart overrides any beat in the same cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    checksum_d = checksum_q;
    cost_d     = 7'd0;
    wr_en_s    = 1'b0;
    if (LoadStart) begin
      state_d    = ST_LOAD;
      ptr_d      = 6'd0;
      acc_d      = 13'd0;
      checksum_d = 13'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (LoadValid) begin
            wr_en_s = 1'b1;
            acc_d   = acc_q + {6'd0, LoadData};
            ptr_d   = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
              state_d    = ST_SERVE;
              checksum_d = acc_d;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SERVE: begin
          cost_d = mem_q[{W, J}];
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    load_ready_d  = (state_d == ST_LOAD);
    table_ready_d = (state_d == ST_SERVE);
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 6'd0;
      acc_q         <= 13'd0;
      checksum_q    <= 13'd0;
      cost_q        <= 7'd0;
      load_ready_q  <= 1'b0;
      table_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      acc_q         <= acc_d;
      checksum_q    <= checksum_d;
      cost_q        <= cost_d;
      load_ready_q  <= load_ready_d;
      table_ready_q <= table_ready_d;
    end
  end

  // Table storage is deliberately unreset; it is only read after a complete load.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_q[ptr_q] <= LoadData;
    end
  end

  assign LoadReady  = load_ready_q;
  assign TableReady = table_ready_q;
  assign Cost       = cost_q;
  assign Checksum   = checksum_q;

endmodule

// File: tb/tb_jam_cost_rom.sv
// Self-checking bench for jam_cost_rom: loads tables, scoreboards lookups against a
// local copy of the loaded data, and exercises restart and asynchronous reset.
module tb_jam_cost_rom;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LoadStart = 1'b0;
  logic        LoadValid = 1'b0;
  logic [6:0]  LoadData = 7'd0;
  logic        LoadReady;
  logic        TableReady;
  logic [2:0]  W = 3'd0;
  logic [2:0]  J = 3'd0;
  logic [6:0]  Cost;
  logic [12:0] Checksum;

  int n_checks = 0;
  int n_pass   = 0;
  int model [64];
  int sb_q [$];

  jam_cost_rom dut (
    .CLK(CLK), .RST(RST), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadReady(LoadReady), .TableReady(TableReady),
    .W(W), .J(J), .Cost(Cost), .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_lr"}, int'(LoadReady), 0);
    check_val({tag, "_tr"}, int'(TableReady), 0);
    check_val({tag, "_cost"}, int'(Cost), 0);
    check_val({tag, "_cs"}, int'(Checksum), 0);
  endtask

  function automatic int beat_val(input int kind, input int idx);
    case (kind)
      0:       return idx % 128;
      1:       return 127;
      default: return 1;
    endcase
  endfunction

  // Entered and left just after a falling edge. A beat sent with LoadStart is junk (127)
  // that must be ignored; nbeats < 64 models an abandoned load.
  task automatic do_load(input int kind, input bit stall, input int nbeats, input int exp_cs);
    int beats = 0;
    int cyc = 0;
    LoadStart = 1'b1;
    LoadValid = 1'b1;
    LoadData  = 7'd127;
    @(negedge CLK);
    LoadStart = 1'b0;
    LoadValid = 1'b0;
    check_val("load_cs_clear", int'(Checksum), 0);
    while (beats < nbeats && cyc < 400) begin
      check_val("load_ready", int'(LoadReady), 1);
      check_val("load_tr_low", int'(TableReady), 0);
      check_val("load_cost0", int'(Cost), 0);
      if (stall && (cyc % 3 == 2)) begin
        LoadValid = 1'b0;
      end else begin
        LoadValid = 1'b1;
        LoadData  = 7'(beat_val(kind, beats));
        model[beats] = beat_val(kind, beats);
        beats++;
      end
      cyc++;
      @(negedge CLK);
    end
    LoadValid = 1'b0;
    if (nbeats == 64) begin
      check_val("load_tr_high", int'(TableReady), 1);
      check_val("load_lr_low", int'(LoadReady), 0);
      check_val("load_checksum", int'(Checksum), exp_cs);
    end else begin
      check_val("partial_tr_low", int'(TableReady), 0);
    end
  endtask

  // Drives one address per cycle and compares Cost one edge later against the model.
  task automatic run_lookups(input int n);
    int w;
    int j;
    for (int i = 0; i <= n; i++) begin
      if (sb_q.size() > 0) check_val("cost", int'(Cost), sb_q.pop_front());
      if (i < n) begin
        if (i == 0) begin w = 3; j = 5; end
        else if (i == 1) begin w = 7; j = 7; end
        else begin w = int'($urandom_range(7, 0)); j = int'($urandom_range(7, 0)); end
        W = 3'(w);
        J = 3'(j);
        sb_q.push_back(model[w * 8 + j]);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_idle("in_reset");
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      W = 3'(i);
      J = 3'(i + 1);
      check_idle("idle");
    end

    do_load(0, 1'b0, 64, 2016);
    check_val("model_3_5", model[29], 29);
    run_lookups(24);

    // Async reset while serving: outputs must clear before any clock edge.
    W = 3'd7;
    J = 3'd7;
    @(posedge CLK);
    #3;
    check_val("pre_rst_cost", int'(Cost), 63);
    RST = 1'b0;
    #1;
    check_val("arst_cost", int'(Cost), 0);
    check_val("arst_tr", int'(TableReady), 0);
    check_val("arst_cs", int'(Checksum), 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      W = 3'(i + 2);
      check_idle("post_rst");
    end

    do_load(1, 1'b1, 64, 8128);
    run_lookups(12);

    do_load(0, 1'b0, 20, 0);
    do_load(2, 1'b0, 64, 64);
    run_lookups(16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
